// File: rtl/simon_pkg.sv
// Shared types, widths and helpers for the Simon playback sequencer.
package simon_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned VAL_W  = 2;
    localparam int unsigned LED_W  = 4;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHOW  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // 2-bit colour value to one-hot LED drive.
    function automatic logic [LED_W-1:0] led_onehot(input logic [VAL_W-1:0] v);
        return 4'b0001 << v;
    endfunction

    // On duration for a playback of len entries (len >= 1). Signed 9-bit
    // arithmetic so a large speed-up floors at min_on instead of wrapping.
    function automatic logic [CNT_W-1:0] calc_on_len(input logic [ADDR_W-1:0] len,
                                                     input int unsigned on_ticks,
                                                     input int unsigned min_on,
                                                     input int unsigned shift);
        logic signed [8:0] step;
        logic signed [8:0] t;
        logic signed [8:0] floor_v;
        step    = signed'({5'b0, len - 4'd1} >> shift);
        t       = signed'(9'(on_ticks)) - step;
        floor_v = signed'(9'(min_on));
        if (t < floor_v) t = floor_v;
        return t[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/simon_playback_seq_tick_timer.sv
// Loadable 8-bit down-counter that stops at zero; times SHOW and GAP intervals.
module tick_timer
    import simon_pkg::*;
(
    input  logic             clk_tick,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk_tick) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/simon_playback_seq.sv
// Plays the stored Simon pattern on the LEDs with timed on/gap intervals.
module simon_playback_seq
    import simon_pkg::*;
#(
    parameter int unsigned N           = 10,
    parameter int unsigned ON_TICKS    = 4,
    parameter int unsigned GAP_TICKS   = 2,
    parameter int unsigned MIN_ON      = 1,
    parameter int unsigned SPEED_SHIFT = 2
) (
    input  logic              clk_tick,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    input  logic [VAL_W-1:0]  seq_val,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [LED_W-1:0]  led,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state
);

    state_t            state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] len_q;
    logic [LED_W-1:0]  led_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  on_len_q;

    logic [ADDR_W-1:0] len_clamped;
    logic              last_entry;
    logic              timer_load;
    logic [CNT_W-1:0]  timer_val;
    logic              timer_zero;

    // Length clamp, last-entry detect and timer load control.
    always_comb begin
        len_clamped = (length > 4'(N)) ? 4'(N) : length;
        last_entry  = ((idx_q + 4'd1) == len_q);
        timer_load  = 1'b0;
        timer_val   = '0;
        if (state_q == ST_FETCH) begin
            timer_load = 1'b1;
            timer_val  = on_len_q - 8'd1;
        end else if (state_q == ST_SHOW && timer_zero && !last_entry) begin
            timer_load = 1'b1;
            timer_val  = 8'(GAP_TICKS - 1);
        end
    end

    tick_timer u_timer (
        .clk_tick   (clk_tick),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .zero_o     (timer_zero)
    );

    // Playback FSM with registered outputs; abort overrides normal flow.
    always_ff @(posedge clk_tick) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            on_len_q  <= 8'(ON_TICKS);
        end else if (abort && (state_q == ST_FETCH || state_q == ST_SHOW || state_q == ST_GAP)) begin
            state_q <= ST_IDLE;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (length != '0) begin
                            len_q     <= len_clamped;
                            idx_q     <= '0;
                            rd_addr_q <= '0;
                            on_len_q  <= calc_on_len(len_clamped, ON_TICKS, MIN_ON, SPEED_SHIFT);
                            state_q   <= ST_FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    led_q   <= led_onehot(seq_val);
                    state_q <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (timer_zero) begin
                        led_q <= '0;
                        if (last_entry) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            rd_addr_q <= idx_q + 4'd1;
                            state_q   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (timer_zero) state_q <= ST_FETCH;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    led_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_addr = rd_addr_q;
    assign led     = led_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign state   = state_q;

endmodule

// File: tb/tb_simon_playback_seq.sv
// Directed, table-driven bench for simon_playback_seq.
module tb_simon_playback_seq;

    logic       clk;
    logic       reset;
    logic       start_a, abort_a;
    logic [3:0] length_a;
    logic [1:0] seq_val_a;
    logic [3:0] rd_addr_a, led_a;
    logic       busy_a, done_a;
    logic [2:0] state_a;

    logic       start_b, abort_b;
    logic [3:0] length_b;
    logic [1:0] seq_val_b;
    logic [3:0] rd_addr_b, led_b;
    logic       busy_b, done_b;
    logic [2:0] state_b;

    logic [1:0] rom [16];

    int checks = 0;
    int errors = 0;

    assign seq_val_a = rom[rd_addr_a];
    assign seq_val_b = rom[rd_addr_b];

    simon_playback_seq dut_a (
        .clk_tick (clk), .reset (reset), .start (start_a), .length (length_a),
        .abort (abort_a), .seq_val (seq_val_a), .rd_addr (rd_addr_a), .led (led_a),
        .busy (busy_a), .done (done_a), .state (state_a)
    );

    simon_playback_seq #(.N(10), .ON_TICKS(2), .GAP_TICKS(2), .MIN_ON(1), .SPEED_SHIFT(0)) dut_b (
        .clk_tick (clk), .reset (reset), .start (start_b), .length (length_b),
        .abort (abort_b), .seq_val (seq_val_b), .rd_addr (rd_addr_b), .led (led_b),
        .busy (busy_b), .done (done_b), .state (state_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       start;
        logic [3:0] length;
        logic       abort;
        logic [3:0] led;
        logic       busy;
        logic       done;
        logic [2:0] state;
        logic [3:0] rd;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Run one playback to completion and check pulse count, widths, colours.
    task automatic play(input bit sel, input logic [3:0] len, input int exp_pulse,
                        input int exp_entries, input int exp_maxrd, input string tag);
        logic [3:0] pled, cled, crd;
        logic       cdone;
        int run, pulses, badlen, badled, maxrd, dones;
        run = 0; pulses = 0; badlen = 0; badled = 0; maxrd = 0; dones = 0;
        pled = '0;
        if (sel) begin start_b = 1'b1; length_b = len; end
        else     begin start_a = 1'b1; length_a = len; end
        tick;
        start_a = 1'b0; start_b = 1'b0;
        for (int g = 0; g < 600 && dones == 0; g++) begin
            tick;
            cled  = sel ? led_b : led_a;
            crd   = sel ? rd_addr_b : rd_addr_a;
            cdone = sel ? done_b : done_a;
            if (int'(crd) > maxrd) maxrd = int'(crd);
            if (cled != '0) begin
                run++;
                if (cled != (4'b0001 << rom[crd])) badled++;
            end else if (pled != '0) begin
                pulses++;
                if (run != exp_pulse) badlen++;
                run = 0;
            end
            if (cdone) dones++;
            pled = cled;
        end
        check({tag, "_done_seen"}, dones, 1);
        check({tag, "_entries"}, pulses, exp_entries);
        check({tag, "_pulse_len_bad"}, badlen, 0);
        check({tag, "_led_colour_bad"}, badled, 0);
        check({tag, "_max_rd_addr"}, maxrd, exp_maxrd);
        tick;
        check({tag, "_idle_after"}, sel ? state_b : state_a, 3'd0);
    endtask

    initial begin
        int n;
        int dcount;
        for (int i = 0; i < 16; i++) rom[i] = 2'd0;
        rom[0] = 2'd2; rom[1] = 2'd0; rom[2] = 2'd1; rom[3] = 2'd3; rom[4] = 2'd2;
        rom[5] = 2'd1; rom[6] = 2'd0; rom[7] = 2'd3; rom[8] = 2'd1; rom[9] = 2'd2;

        //             start  len    abort   led       busy  done  state  rd
        tbl[0]  = '{1'b1, 4'd2, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd1, 4'd0};
        tbl[1]  = '{1'b0, 4'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 3'd2, 4'd0};
        tbl[2]  = '{1'b1, 4'd5, 1'b0, 4'b0100, 1'b1, 1'b0, 3'd2, 4'd0};
        tbl[3]  = '{1'b0, 4'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 3'd2, 4'd0};
        tbl[4]  = '{1'b0, 4'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 3'd2, 4'd0};
        tbl[5]  = '{1'b0, 4'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd3, 4'd1};
        tbl[6]  = '{1'b0, 4'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd3, 4'd1};
        tbl[7]  = '{1'b0, 4'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd1, 4'd1};
        tbl[8]  = '{1'b0, 4'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 3'd2, 4'd1};
        tbl[9]  = '{1'b0, 4'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 3'd2, 4'd1};
        tbl[10] = '{1'b0, 4'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 3'd2, 4'd1};
        tbl[11] = '{1'b0, 4'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 3'd2, 4'd1};
        tbl[12] = '{1'b0, 4'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 3'd4, 4'd1};
        tbl[13] = '{1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'd1};
        tbl[14] = '{1'b1, 4'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 3'd4, 4'd1};
        tbl[15] = '{1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'd1};
        tbl[16] = '{1'b1, 4'd1, 1'b1, 4'b0000, 1'b1, 1'b0, 3'd1, 4'd0};
        tbl[17] = '{1'b0, 4'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 3'd2, 4'd0};
        tbl[18] = '{1'b0, 4'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 4'd0};
        tbl[19] = '{1'b0, 4'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 4'd0};

        reset = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; length_a = '0;
        start_b = 1'b0; abort_b = 1'b0; length_b = '0;
        tick; tick;
        check("reset_state", state_a, 3'd0);
        check("reset_led", led_a, 4'd0);
        check("reset_busy", busy_a, 1'b0);
        check("reset_done", done_a, 1'b0);
        check("reset_rd_addr", rd_addr_a, 4'd0);
        reset = 1'b0;

        // Cycle-accurate basic playback, start-while-busy, zero length, start+abort.
        for (int i = 0; i < 20; i++) begin
            start_a  = tbl[i].start;
            length_a = tbl[i].length;
            abort_a  = tbl[i].abort;
            tick;
            check($sformatf("v%0d_led", i), led_a, tbl[i].led);
            check($sformatf("v%0d_busy", i), busy_a, tbl[i].busy);
            check($sformatf("v%0d_done", i), done_a, tbl[i].done);
            check($sformatf("v%0d_state", i), state_a, tbl[i].state);
            check($sformatf("v%0d_rd_addr", i), rd_addr_a, tbl[i].rd);
        end
        start_a = 1'b0; abort_a = 1'b0; length_a = '0;

        // Clamp 13 -> 10 entries with on_len = 4 - (9>>2) = 2.
        play(1'b0, 4'd13, 2, 10, 9, "clamp");
        // Floor: 2 - 9 underflows to MIN_ON = 1.
        play(1'b1, 4'd10, 1, 10, 9, "floor");

        // Abort in the 3rd SHOW cycle of entry 1.
        start_a = 1'b1; length_a = 4'd3;
        tick;
        start_a = 1'b0;
        n = 0;
        for (int g = 0; g < 100 && n < 3; g++) begin
            tick;
            if (state_a == 3'd2 && rd_addr_a == 4'd1) n++;
        end
        check("abort_reach_show", n, 3);
        abort_a = 1'b1;
        tick;
        abort_a = 1'b0;
        check("abort_led", led_a, 4'd0);
        check("abort_busy", busy_a, 1'b0);
        check("abort_state", state_a, 3'd0);
        check("abort_done", done_a, 1'b0);
        check("abort_rd_hold", rd_addr_a, 4'd1);
        dcount = 0;
        for (int g = 0; g < 20; g++) begin
            tick;
            if (done_a) dcount++;
        end
        check("abort_no_done", dcount, 0);
        start_a = 1'b1; length_a = 4'd1;
        tick;
        start_a = 1'b0;
        check("restart_rd_addr", rd_addr_a, 4'd0);
        check("restart_state", state_a, 3'd1);
        tick;
        check("restart_led", led_a, 4'b0100);
        dcount = 0;
        for (int g = 0; g < 50 && dcount == 0; g++) begin
            tick;
            if (done_a) dcount++;
        end
        check("restart_done", dcount, 1);
        tick;

        // Synchronous reset while in GAP.
        start_a = 1'b1; length_a = 4'd3;
        tick;
        start_a = 1'b0;
        n = 0;
        for (int g = 0; g < 100 && n == 0; g++) begin
            tick;
            if (state_a == 3'd3) n = 1;
        end
        check("gap_reached", n, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("gaprst_state", state_a, 3'd0);
        check("gaprst_led", led_a, 4'd0);
        check("gaprst_busy", busy_a, 1'b0);
        check("gaprst_done", done_a, 1'b0);
        check("gaprst_rd_addr", rd_addr_a, 4'd0);
        tick;
        check("gaprst_stays_idle", state_a, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
